// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control unit
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_LUI, S_AUIPC, S_JAL, S_JALR,
    S_LINK, S_BRANCH, S_FAULT, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_ZERO  = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // alu_op tells the decoder whether to force ADD/SUB or look at funct3/funct7
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_mem_wait(input state_t s);
    return s inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational alu_op/funct decode to alu_control
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only register-register ops subtract; ADDI's imm bits land in funct7
          3'b000: alu_control = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I control FSM; CTRL_ILLEGAL_TRAP_EN adds the illegal trap
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             less_than,
  input  logic             signed_less_than,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic [1:0]       mem_size,
  output logic             mem_unsigned,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [3:0]       alu_control,
  output logic [2:0]       imm_src,
  output logic [CNT_W-1:0] instret,
  output logic             fault
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 2);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        alu_op;
  logic              taken, timeout;
  logic              mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;

  assign mem_size     = funct3[1:0];
  assign mem_unsigned = funct3[2];
  assign imm_src      = imm_sel(opcode);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_control)
  );

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = signed_less_than;
      3'b101:  taken = !signed_less_than;
      3'b110:  taken = less_than;
      3'b111:  taken = !less_than;
      default: taken = 1'b0;
    endcase
  end

  // a late mem_ready on the limit cycle still completes the access
  assign timeout = (MEM_WAIT_MAX > 0) && is_mem_wait(state) && !mem_ready &&
                   (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_enc;

  always_comb begin
    case (opcode)
      OP_LOAD:   illegal_enc = funct3 inside {3'b011, 3'b110, 3'b111};
      OP_STORE:  illegal_enc = funct3 >= 3'b011;
      OP_BRANCH: illegal_enc = funct3 inside {3'b010, 3'b011};
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: illegal_enc = 1'b0;
      default:   illegal_enc = 1'b1;
    endcase
  end
`endif

  always_comb begin
    state_next    = state;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = SRCA_OLDPC;
    alu_src_b     = SRCB_FOUR;
    result_src    = RES_ALU;
    alu_op        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_next   = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_REG:            state_next = S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_BRANCH:         state_next = S_BRANCH;
          default:           state_next = S_FETCH;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (illegal_enc) state_next = S_TRAP;
`endif
      end
      S_MEM_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready)    state_next = S_MEM_WB;
        else if (timeout) state_next = S_FAULT;
      end
      S_MEM_WB: begin
        result_src    = RES_MEM;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        adr_src       = 1'b1;
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_FAULT;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        state_next = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_b  = SRCB_IMM;
        state_next = S_ALU_WB;
      end
      S_JAL: begin
        // target was captured in ALUOut during DECODE; ALU now forms the link value
        result_src   = RES_ALUOUT;
        pc_write_raw = 1'b1;
        state_next   = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_IMM;
        pc_write_raw = 1'b1;
        state_next   = S_LINK;
      end
      S_LINK: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_SUB;
        result_src   = RES_ALUOUT;
        pc_write_raw = taken;
        state_next   = S_FETCH;
      end
      default: state_next = state;
    endcase
  end

  // reset kills any enable in the same cycle, abandoning an in-flight access
  assign mem_req   = mem_req_raw   & reset;
  assign mem_write = mem_write_raw & reset;
  assign ir_write  = ir_write_raw  & reset;
  assign pc_write  = pc_write_raw  & reset;
  assign reg_write = reg_write_raw & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      instret  <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state != S_FETCH && state_next == S_FETCH)
        instret <= instret + CNT_W'(1);
      if (is_mem_wait(state) && state_next == state && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (state_next == S_FAULT)
        fault <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (state_next == S_TRAP)
        illegal <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm (CNT_W=4, MEM_WAIT_MAX=4)
module tb_mc_control_fsm;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

  localparam int B_F = 0, B_D = 1, B_MA = 2, B_MR = 3, B_MWB = 4, B_MW = 5, B_ER = 6;
  localparam int B_EI = 7, B_AWB = 8, B_LUI = 9, B_AUIPC = 10, B_JAL = 11, B_JALR = 12;
  localparam int B_LINK = 13, B_BR = 14, B_FAULT = 15, B_TRAP = 16, B_RST = 17;

  logic       clk = 1'b0;
  logic       reset, zero, less_than, signed_less_than, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       mem_req, mem_write, mem_unsigned, adr_src, ir_write, pc_write, reg_write, fault;
  logic [1:0] mem_size, alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control, instret;
  logic [2:0] imm_src;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(4), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .less_than(less_than), .signed_less_than(signed_less_than),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
    .instret(instret), .fault(fault)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed { logic [16:0] val; logic [16:0] mask; } exp_t;
  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [3:0] alu; } alu_vec_t;
  typedef struct packed { logic [2:0] f3; logic z; logic lt; logic slt; logic tk; } br_vec_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  string      cur = "";
  logic [3:0] exp_instret = '0;
  logic [16:0] obs;

  assign obs = {fault, mem_req, mem_write, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, adr_src, alu_control};

  alu_vec_t av [14] = '{
    '{OPR, 3'b000, 7'h20, A_SUB}, '{OPR, 3'b000, 7'h00, A_ADD}, '{OPR, 3'b001, 7'h00, A_SLL},
    '{OPR, 3'b010, 7'h00, A_SLT}, '{OPR, 3'b011, 7'h00, A_SLTU}, '{OPR, 3'b100, 7'h00, A_XOR},
    '{OPR, 3'b101, 7'h00, A_SRL}, '{OPR, 3'b101, 7'h20, A_SRA}, '{OPR, 3'b110, 7'h00, A_OR},
    '{OPR, 3'b111, 7'h00, A_AND}, '{OPI, 3'b000, 7'h20, A_ADD}, '{OPI, 3'b101, 7'h20, A_SRA},
    '{OPI, 3'b101, 7'h00, A_SRL}, '{OPI, 3'b011, 7'h00, A_SLTU}};

  br_vec_t bv [8] = '{
    '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
    '{3'b100, 1'b0, 1'b0, 1'b1, 1'b1}, '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0},
    '{3'b101, 1'b0, 1'b1, 1'b0, 1'b1}, '{3'b110, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1}, '{3'b111, 1'b0, 1'b1, 1'b0, 1'b0}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference per-cycle outputs: {fault, en[4:0], a, b, res, adr, alu}
  function automatic exp_t exp_of(input int s, input logic r, input logic tk, input logic [3:0] alu);
    logic f, mf, ma, mb, mrs, madr, mal, adr;
    logic [4:0] en;
    logic [1:0] a, b, rs;
    logic [3:0] al;
    exp_t e;
    f = 0; mf = 1; ma = 0; mb = 0; mrs = 0; madr = 0; mal = 0; adr = 0;
    en = '0; a = '0; b = '0; rs = '0; al = A_ADD;
    case (s)
      B_F:     begin en = {1'b1, 1'b0, r, r, 1'b0}; a = 2'b01; b = 2'b10; rs = 2'b10;
                     ma = 1; mb = 1; mrs = 1; madr = 1; mal = 1; end
      B_D:     begin a = 2'b01; b = 2'b01; ma = 1; mb = 1; mal = 1; end
      B_MA:    begin a = 2'b10; b = 2'b01; ma = 1; mb = 1; mal = 1; end
      B_MR:    begin en = 5'b10000; adr = 1; madr = 1; end
      B_MWB:   begin en = 5'b00001; rs = 2'b01; mrs = 1; end
      B_MW:    begin en = 5'b11000; adr = 1; madr = 1; end
      B_ER:    begin a = 2'b10; b = 2'b00; al = alu; ma = 1; mb = 1; mal = 1; end
      B_EI:    begin a = 2'b10; b = 2'b01; al = alu; ma = 1; mb = 1; mal = 1; end
      B_AWB:   begin en = 5'b00001; rs = 2'b00; mrs = 1; end
      B_LUI:   begin a = 2'b00; b = 2'b01; ma = 1; mb = 1; mal = 1; end
      B_AUIPC: begin a = 2'b01; b = 2'b01; ma = 1; mb = 1; mal = 1; end
      B_JAL:   begin en = 5'b00010; a = 2'b01; b = 2'b10; rs = 2'b00;
                     ma = 1; mb = 1; mrs = 1; mal = 1; end
      B_JALR:  begin en = 5'b00010; a = 2'b10; b = 2'b01; rs = 2'b10;
                     ma = 1; mb = 1; mrs = 1; mal = 1; end
      B_LINK:  begin en = 5'b00001; a = 2'b01; b = 2'b10; rs = 2'b10;
                     ma = 1; mb = 1; mrs = 1; mal = 1; end
      B_BR:    begin en = {3'b000, tk, 1'b0}; a = 2'b10; b = 2'b00; rs = 2'b00; al = A_SUB;
                     ma = 1; mb = 1; mrs = 1; mal = 1; end
      B_FAULT: f = 1;
      B_RST:   mf = 0;
      default: ;
    endcase
    e.val  = {f, en, a, b, rs, adr, al};
    e.mask = {mf, 5'h1f, {2{ma}}, {2{mb}}, {2{mrs}}, madr, {4{mal}}};
    return e;
  endfunction

  task automatic cyc(input int s, input logic r, input logic tk, input logic [3:0] alu);
    exp_t e;
    mem_ready = r;
    sb.push_back(exp_of(s, r, tk, alu));
    @(negedge clk);
    e = sb.pop_front();
    check_val($sformatf("%s/st%0d", cur, s), 32'(obs & e.mask), 32'(e.val & e.mask));
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle();
    reset = 1'b0;
    cyc(B_RST, 1'b1, 1'b0, A_ADD);
    reset = 1'b1;
    exp_instret = '0;
    check_val({cur, "/rst_instret"}, 32'(instret), 32'(0));
    check_val({cur, "/rst_fault"}, 32'(fault), 32'(0));
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input int fd, input int md, input logic tk, input logic [3:0] alu);
    cur = nm; opcode = op; funct3 = f3; funct7 = f7;
    repeat (fd) cyc(B_F, 1'b0, 1'b0, A_ADD);
    cyc(B_F, 1'b1, 1'b0, A_ADD);
    cyc(B_D, 1'b0, 1'b0, A_ADD);
    case (op)
      OPR:   begin cyc(B_ER, 1'b0, 1'b0, alu); cyc(B_AWB, 1'b0, 1'b0, alu); end
      OPI:   begin cyc(B_EI, 1'b0, 1'b0, alu); cyc(B_AWB, 1'b0, 1'b0, alu); end
      LOAD:  begin
               cyc(B_MA, 1'b0, 1'b0, alu);
               repeat (md) cyc(B_MR, 1'b0, 1'b0, alu);
               cyc(B_MR, 1'b1, 1'b0, alu);
               cyc(B_MWB, 1'b0, 1'b0, alu);
             end
      STORE: begin
               cyc(B_MA, 1'b0, 1'b0, alu);
               repeat (md) cyc(B_MW, 1'b0, 1'b0, alu);
               cyc(B_MW, 1'b1, 1'b0, alu);
             end
      LUI:   begin cyc(B_LUI, 1'b0, 1'b0, alu); cyc(B_AWB, 1'b0, 1'b0, alu); end
      AUIPC: begin cyc(B_AUIPC, 1'b0, 1'b0, alu); cyc(B_AWB, 1'b0, 1'b0, alu); end
      JAL:   begin cyc(B_JAL, 1'b0, 1'b0, alu); cyc(B_AWB, 1'b0, 1'b0, alu); end
      JALR:  begin cyc(B_JALR, 1'b0, 1'b0, alu); cyc(B_LINK, 1'b0, 1'b0, alu); end
      BR:    cyc(B_BR, 1'b0, tk, alu);
      default: ;
    endcase
    exp_instret = exp_instret + 4'd1;
    check_val({nm, "/instret"}, 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opcode = OPI; funct3 = '0; funct7 = '0;
    zero = 1'b0; less_than = 1'b0; signed_less_than = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cur = "reset";
    rst_cycle();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_val("reset/illegal", 32'(illegal), 32'(0));
`endif

    for (int i = 0; i < 14; i++)
      run($sformatf("alu%0d", i), av[i].op, av[i].f3, av[i].f7, 0, 0, 1'b0, av[i].alu);
    check_val("imm_i", 32'(imm_src), 32'(3'b000));

    for (int i = 0; i < 8; i++) begin
      zero = bv[i].z; less_than = bv[i].lt; signed_less_than = bv[i].slt;
      run($sformatf("br%0d", i), BR, bv[i].f3, 7'h00, 0, 0, bv[i].tk, A_SUB);
    end
    check_val("imm_b", 32'(imm_src), 32'(3'b010));

    run("lw_wait3", LOAD, 3'b010, 7'h00, 0, 3, 1'b0, A_ADD);
    check_val("lw_size", 32'(mem_size), 32'(2'b10));
    check_val("lw_unsigned", 32'(mem_unsigned), 32'(0));
    run("lhu_wait4", LOAD, 3'b101, 7'h00, 0, 4, 1'b0, A_ADD);
    check_val("lhu_size", 32'(mem_size), 32'(2'b01));
    check_val("lhu_unsigned", 32'(mem_unsigned), 32'(1));
    run("sw_fetch4", STORE, 3'b010, 7'h00, 4, 2, 1'b0, A_ADD);
    check_val("imm_s", 32'(imm_src), 32'(3'b001));
    run("lui", LUI, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);
    check_val("imm_u", 32'(imm_src), 32'(3'b100));
    run("auipc", AUIPC, 3'b000, 7'h00, 1, 0, 1'b0, A_ADD);
    run("jal", JAL, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);
    check_val("imm_j", 32'(imm_src), 32'(3'b011));
    run("jalr", JALR, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);

`ifdef CTRL_ILLEGAL_TRAP_EN
    cur = "trap"; opcode = 7'b0000000; funct3 = '0; funct7 = '0;
    cyc(B_F, 1'b1, 1'b0, A_ADD);
    cyc(B_D, 1'b0, 1'b0, A_ADD);
    repeat (3) cyc(B_TRAP, 1'b1, 1'b0, A_ADD);
    check_val("trap/illegal", 32'(illegal), 32'(1));
    check_val("trap/instret", 32'(instret), 32'(exp_instret));
    rst_cycle();
    check_val("trap/illegal_cleared", 32'(illegal), 32'(0));
`else
    run("nop_illegal", 7'b0000000, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);
`endif

    cur = "abort"; opcode = LOAD; funct3 = 3'b010;
    cyc(B_F, 1'b1, 1'b0, A_ADD);
    cyc(B_D, 1'b0, 1'b0, A_ADD);
    cyc(B_MA, 1'b0, 1'b0, A_ADD);
    cyc(B_MR, 1'b0, 1'b0, A_ADD);
    rst_cycle();
    run("post_abort", OPI, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);

    cur = "fault"; opcode = LUI;
    repeat (5) cyc(B_F, 1'b0, 1'b0, A_ADD);
    repeat (3) cyc(B_FAULT, 1'b1, 1'b0, A_ADD);
    rst_cycle();
    run("post_fault", OPR, 3'b000, 7'h00, 0, 0, 1'b0, A_ADD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
